// File: rtl/led_pkg.sv
// led_pkg: mode encodings, start patterns and bounce direction shared by the LED sequencer.
package led_pkg;
  typedef enum logic [1:0] {
    MODE_ALT    = 2'd0,
    MODE_CHASE  = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_FILL   = 2'd3
  } mode_t;
  localparam logic [7:0] LED_START_ALT    = 8'h55;
  localparam logic [7:0] LED_START_CHASE  = 8'h01;
  localparam logic [7:0] LED_START_BOUNCE = 8'h01;
  localparam logic [7:0] LED_START_FILL   = 8'h00;
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
  function automatic logic [7:0] start_val(input mode_t m);
    return m == MODE_ALT    ? LED_START_ALT :
           m == MODE_CHASE  ? LED_START_CHASE :
           m == MODE_BOUNCE ? LED_START_BOUNCE : LED_START_FILL;
  endfunction
endpackage

// File: rtl/led_step_tick.sv
// led_step_tick: prescaler emitting one tick every (STEP_DIV >> speed) cycles, with clear and hold.
module led_step_tick #(
  parameter int STEP_DIV = 12_500_000,
  parameter int CNT_W    = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       hold,
  input  logic [1:0] speed,
  output logic       tick
);
  localparam logic [CNT_W-1:0] DIV = CNT_W'(STEP_DIV);
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] lim;
  assign lim = DIV >> speed;
  // >= rather than == so a speed change below the current count still ticks at once
  assign tick = !clr && !hold && (cnt >= lim - CNT_W'(1));
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr || tick) cnt <= '0;
    else if (!hold) cnt <= cnt + CNT_W'(1);
endmodule

// File: rtl/led_pattern_seq.sv
// led_pattern_seq: steps one of four LED patterns at a prescaled rate; mode_next cycles the mode.
// Define LED_SEQ_PAUSE_EN to add the pause input that freezes the sequence.
module led_pattern_seq
  import led_pkg::*;
#(
  parameter int STEP_DIV = 12_500_000,
  parameter int CNT_W    = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_next,
  input  logic [1:0] speed,
`ifdef LED_SEQ_PAUSE_EN
  input  logic       pause,
`endif
  output logic [7:0] led,
  output logic [1:0] mode
);
  mode_t      mode_q, mode_d;
  logic [7:0] led_q, led_d;
  logic       dir_q, dir_d;
  logic       tick, hold, onehot, filled, turn;
`ifdef LED_SEQ_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif
  led_step_tick #(.STEP_DIV(STEP_DIV), .CNT_W(CNT_W)) u_tick (
    .clk(clk), .rst(rst), .clr(mode_next), .hold(hold), .speed(speed), .tick(tick)
  );
  assign onehot = (led_q != 8'd0) && ((led_q & (led_q - 8'd1)) == 8'd0);
  assign filled = (led_q & (led_q + 8'd1)) == 8'd0;
  // direction flips on the step that leaves an end position
  assign turn = led_q == 8'h80 ? DIR_RIGHT : led_q == 8'h01 ? DIR_LEFT : dir_q;
  always_comb begin
    mode_d = mode_q;
    led_d  = led_q;
    dir_d  = dir_q;
    if (mode_next) begin
      mode_d = mode_t'(mode_q + 2'd1);
      led_d  = start_val(mode_d);
      dir_d  = DIR_LEFT;
    end else if (tick) begin
      unique case (mode_q)
        MODE_ALT:    led_d = led_q == LED_START_ALT ? 8'hAA : LED_START_ALT;
        MODE_CHASE:  led_d = onehot ? {led_q[6:0], led_q[7]} : LED_START_CHASE;
        MODE_BOUNCE: begin
          led_d = !onehot ? LED_START_BOUNCE : turn ? led_q >> 1 : led_q << 1;
          dir_d = onehot ? turn : DIR_LEFT;
        end
        MODE_FILL:   led_d = (filled && led_q != 8'hFF) ? {led_q[6:0], 1'b1} : LED_START_FILL;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mode_q <= MODE_ALT;
      led_q  <= LED_START_ALT;
      dir_q  <= DIR_LEFT;
    end else begin
      mode_q <= mode_d;
      led_q  <= led_d;
      dir_q  <= dir_d;
    end
  assign led  = led_q;
  assign mode = mode_q;
endmodule

// File: tb/tb_led_pattern_seq.sv
// tb_led_pattern_seq: scoreboard bench; each expected LED/mode change carries its predicted cycle.
module tb_led_pattern_seq;
  typedef struct {
    logic [7:0] led;
    logic [1:0] mode;
    int         t;
  } ev_t;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mode_next = 1'b0;
  logic [1:0] speed = 2'd0;
`ifdef LED_SEQ_PAUSE_EN
  logic       pause = 1'b0;
`endif
  logic [7:0] led;
  logic [1:0] mode;
  ev_t        sb[$];
  logic [7:0] vq[$];
  logic [9:0] prev = {2'd0, 8'h55};
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;
  always #5 clk = ~clk;
  led_pattern_seq #(.STEP_DIV(8), .CNT_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .mode_next(mode_next),
    .speed(speed),
`ifdef LED_SEQ_PAUSE_EN
    .pause(pause),
`endif
    .led(led),
    .mode(mode)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic cyc1();
    ev_t e;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if ({mode, led} !== prev) begin
      if (sb.size() == 0) check("extra_change", {mode, led}, prev);
      else begin
        e = sb.pop_front();
        check("led", led, e.led);
        check("mode", mode, e.mode);
        check("when", cyc, e.t);
      end
      prev = {mode, led};
    end
  endtask
  task automatic run(input int n);
    repeat (n) cyc1();
  endtask
  task automatic push(input logic [7:0] l, input logic [1:0] m, input int t);
    sb.push_back('{l, m, t});
  endtask
  task automatic push_vq(input logic [1:0] m, input int lim);
    int b = cyc;
    foreach (vq[i]) push(vq[i], m, b + lim * (i + 1));
  endtask
  task automatic pulse(input logic [1:0] m, input logic [7:0] s);
    mode_next = 1'b1;
    push(s, m, cyc + 1);
    cyc1();
    mode_next = 1'b0;
  endtask
  initial begin
    run(3);
    check("rst_led", led, 8'h55);
    check("rst_mode", mode, 2'd0);
    rst = 1'b0;
    vq = '{8'hAA, 8'h55, 8'hAA, 8'h55, 8'hAA};
    push_vq(2'd0, 8);
    run(40);
    speed = 2'd1;
    pulse(2'd1, 8'h01);
    vq = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    push_vq(2'd1, 4);
    run(32);
    speed = 2'd2;
    pulse(2'd2, 8'h01);
    vq = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
           8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};
    push_vq(2'd2, 2);
    run(32);
    speed = 2'd1;
    pulse(2'd3, 8'h00);
    vq = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h00, 8'h01};
    push_vq(2'd3, 4);
    run(40);
    run(3);
    pulse(2'd0, 8'h55);
    speed = 2'd0;
    push(8'hAA, 2'd0, cyc + 8);
    run(8);
    run(5);
    speed = 2'd2;
    push(8'h55, 2'd0, cyc + 1);
    push(8'hAA, 2'd0, cyc + 3);
    run(3);
    speed = 2'd0;
`ifdef LED_SEQ_PAUSE_EN
    run(3);
    pause = 1'b1;
    run(20);
    pause = 1'b0;
    push(8'h55, 2'd0, cyc + 5);
    run(5);
    run(3);
    pause = 1'b1;
    run(2);
    pulse(2'd1, 8'h01);
    run(6);
    pause = 1'b0;
    push(8'h02, 2'd1, cyc + 8);
    run(8);
`endif
    run(2);
    #2 rst = 1'b1;
    #1;
    check("arst_led", led, 8'h55);
    check("arst_mode", mode, 2'd0);
    prev = {2'd0, 8'h55};
    run(2);
    rst = 1'b0;
    push(8'hAA, 2'd0, cyc + 8);
    run(8);
    check("pending", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/led_pattern_seq.md
# led_pattern_seq

Sequencer for the 8-LED board bank: cycles one of four LED patterns (alternate, chaser, bounce, fill) at a programmable step rate derived from the system clock. It replaces direct clock-driven LED toggling with a prescaled, mode-selectable sequence. It sits between the board push-button front end and the `led[7:0]` pins.

## Interface
- `STEP_DIV`, default 12_500_000: base clock cycles per pattern step; must be ≥ 8.
- `CNT_W`, default 24: prescaler counter width; must satisfy 2^CNT_W > STEP_DIV.
- `clk`  input  1  system clock; the only clock.
- `rst`  input  1  asynchronous, active-high reset.
- `mode_next`  input  1  one-cycle pulse, synchronous to `clk`; advances to the next mode.
- `speed`  input  2  rate select; step limit = `STEP_DIV >> speed`.
- `pause`  input  1  present only with `LED_SEQ_PAUSE_EN`; holds the sequence.
- `led`  output  8  registered LED pattern.
- `mode`  output  2  registered current mode: 0 ALT, 1 CHASE, 2 BOUNCE, 3 FILL.

## Operation
- Reset values: `mode`=0 (ALT); `led`=8'h55; prescaler=0; bounce direction=left.
- Prescaler: counts up every cycle. The step tick fires in the cycle where count ≥ limit−1; the count then returns to 0.
- On a tick, `led` advances by mode:
  - ALT: toggles between 8'h55 and 8'hAA.
  - CHASE: rotates left, 8'h01→8'h02→…→8'h80→8'h01.
  - BOUNCE: shifts one position in the current direction. When `led` reaches 8'h80 the direction becomes right; at 8'h01 it becomes left. Sequence: 01,02,…,80,40,…,01,02… (period 14 steps).
  - FILL: `led` ← {`led`[6:0],1'b1} until 8'hFF, then 8'h00. Sequence: 00,01,03,…,FF,00 (period 9 steps).
- `mode_next`:
  - `mode` ← `mode`+1 mod 4 (3 wraps to 0).
  - `led` loads the new mode's start value: ALT 55, CHASE 01, BOUNCE 01, FILL 00.
  - Prescaler clears to 0; bounce direction resets to left.
- `mode_next` coincident with a tick: `mode_next` wins and the tick is discarded.
- Change of `speed` mid-count: the new limit applies immediately. If count is already ≥ new limit−1, a tick fires in that cycle.
- Illegal `led` value (unreachable): the next tick loads the mode's start value.

## Timing
- Prescaler tick to `led` update: the `led` change is visible 1 cycle after the tick cycle.
- Step period: exactly `STEP_DIV >> speed` cycles in steady state.
- `mode_next` to outputs: `mode` and `led` both update 1 cycle after the pulse cycle.
  - The first step in the new mode occurs `limit` cycles after that update.
- `rst` acts asynchronously on all registers, including mid-step.
  - The first tick after release occurs `limit` cycles after the first active clock edge.
- `mode_next` held high for N cycles advances `mode` N times. Debouncing and edge detection are upstream.

## Configuration
- `LED_SEQ_PAUSE_EN` defined:
  - `pause` port exists.
  - While `pause`=1 the prescaler holds its count, no ticks occur, and `led` is frozen.
  - `mode_next` is still honoured while paused: it loads the start value and clears the prescaler.
  - Deasserting `pause` resumes from the held count.
- Not defined:
  - No `pause` port.
  - The sequence runs continuously.

## Structure
- Shared package `led_pkg`:
  - mode encodings `MODE_ALT`/`MODE_CHASE`/`MODE_BOUNCE`/`MODE_FILL`;
  - start-value constants `LED_START_ALT`=8'h55, `LED_START_CHASE`=8'h01, `LED_START_BOUNCE`=8'h01, `LED_START_FILL`=8'h00.
- Sub-module `led_step_tick`:
  - prescaler with inputs `clk`, `rst`, `clr`, `hold`, `speed`; output `tick`; parameters `STEP_DIV`, `CNT_W`.
  - It is reusable by other board-display blocks.
- Top level holds the mode register, direction flag and pattern next-state logic.

## Test plan
All scenarios use `STEP_DIV`=8.
- Reset, then run 40 cycles at `speed`=0 → `mode`=0; `led` = 55, AA, 55, … with a change every 8 cycles; the first change 8 cycles after reset release.
- CHASE mode (one `mode_next` pulse), `speed`=1 → `led` = 01,02,04,…,80,01 with a change every 4 cycles.
- BOUNCE mode, 16 steps → 01,02,…,80,40,…,01,02; the direction flips exactly at 80 and 01.
- FILL mode, 10 steps → 00,01,03,07,0F,1F,3F,7F,FF,00.
- `mode_next` asserted in the same cycle as a tick while in mode 3 → next cycle `mode`=0, `led`=55, prescaler=0; no extra step.
- `LED_SEQ_PAUSE_EN`: `pause`=1 for 20 cycles mid-step → `led` is constant. After release the remaining count completes before the next step. A `mode_next` during pause loads the start value.
